// File: rtl/stop_watch_pkg.sv
// -----------------------------------------------------------------------------
// stop_watch_pkg
// Shared types and constants for the parametrised BCD stopwatch.
//   bcd_t            : one 4-bit BCD digit
//   state_e          : FSM state encoding {IDLE, RUN, PAUSE}
//   BCD_MAX/BCD_MIN  : digit range limits
//   bcd_is_terminal  : true when a digit sits at the end of its range for the
//                      current count direction (9 counting up, 0 counting down)
// -----------------------------------------------------------------------------
package stop_watch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic logic bcd_is_terminal(input bcd_t q, input logic up);
        logic term;
        if (up) begin
            term = (q == BCD_MAX);
        end else begin
            term = (q == BCD_MIN);
        end
        return term;
    endfunction

endpackage

// File: rtl/stop_watch_bcd_param_digit_cell.sv
// -----------------------------------------------------------------------------
// bcd_digit_cell
// One BCD digit of the stopwatch counter chain.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (digit -> 0)
//   clr    in   synchronous clear (digit -> 0)
//   en     in   chain enable: a count step is taking place this cycle
//   up     in   1 = count up, 0 = count down
//   cin    in   ripple carry/borrow from the digit below (tie 1 on digit 0)
//   q      out  registered digit value, always 0..9
//   cout   out  terminal value (9 up / 0 down) AND enabled step; feeds the
//                next digit's cin
// -----------------------------------------------------------------------------
module bcd_digit_cell
    import stop_watch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic up,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    bcd_t q_q;
    bcd_t q_d;
    logic step_s;
    logic term_s;

    // Digit steps only when the chain is enabled and every lower digit rolled over.
    always_comb begin
        step_s = en & cin;
        term_s = bcd_is_terminal(q_q, up);
        cout   = term_s & step_s;
    end

    // Next digit value: roll 9->0 going up, 0->9 going down, else +/-1.
    always_comb begin
        q_d = q_q;
        if (step_s) begin
            if (term_s) begin
                if (up) begin
                    q_d = BCD_MIN;
                end else begin
                    q_d = BCD_MAX;
                end
            end else if (up) begin
                q_d = q_q + 4'd1;
            end else begin
                q_d = q_q - 4'd1;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Digit register with reset and clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= BCD_MIN;
        end else if (clr) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stop_watch_bcd_param.sv
// -----------------------------------------------------------------------------
// stop_watch_bcd_param
// Parametrised N-digit BCD stopwatch with prescaler, up/down counting,
// IDLE/RUN/PAUSE FSM, wrap-or-saturate end handling and sticky overflow flag.
// Optional lap capture register enabled by macro STOP_WATCH_LAP_EN.
// Parameters:
//   NUM_DIGITS  number of BCD digits (1..8), digit 0 least significant
//   TICK_DIV    clk cycles per count tick (>=2)
//   WRAP        1: roll over at end of range, 0: saturate and hold
// Ports:
//   clk_amisha        in   clock
//   reset_amisha      in   synchronous active-high reset
//   go_amisha         in   level: 1 run, 0 pause
//   clr_amisha        in   synchronous clear of count, prescaler, flags
//   up_amisha         in   count direction, sampled on tick cycles
//   d_amisha          out  BCD digits, [3:0] = digit 0
//   tick_amisha       out  pulse in the cycle a count step occurs
//   running_amisha    out  FSM is in RUN
//   ovf_amisha        out  sticky over/underflow flag
//   (STOP_WATCH_LAP_EN) lap_amisha in, lap_d_amisha out, lap_valid_amisha out
// -----------------------------------------------------------------------------
module stop_watch_bcd_param
    import stop_watch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 5_000_000,
    parameter int WRAP       = 1
) (
    input  logic                    clk_amisha,
    input  logic                    reset_amisha,
    input  logic                    go_amisha,
    input  logic                    clr_amisha,
    input  logic                    up_amisha,
    output logic [4*NUM_DIGITS-1:0] d_amisha,
    output logic                    tick_amisha,
    output logic                    running_amisha,
    output logic                    ovf_amisha
`ifdef STOP_WATCH_LAP_EN
    ,
    input  logic                    lap_amisha,
    output logic [4*NUM_DIGITS-1:0] lap_d_amisha,
    output logic                    lap_valid_amisha
`endif
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_PAUSE = PAUSE;

    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic [PRESC_W-1:0]      presc_q;
    logic [PRESC_W-1:0]      presc_d;
    logic                    ovf_q;
    logic                    ovf_d;
    logic                    tick_s;
    logic                    all_nine_s;
    logic                    all_zero_s;
    logic                    at_end_s;
    logic                    step_en_s;
    logic                    end_event_s;
    logic [NUM_DIGITS:0]     carry_s;
    logic [4*NUM_DIGITS-1:0] d_s;

    // Run/pause FSM; clear forces IDLE ahead of go.
    always_comb begin
        state_d = state_q;
        if (clr_amisha) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = go_amisha ? ST_RUN : ST_IDLE;
                ST_RUN:   state_d = go_amisha ? ST_RUN : ST_PAUSE;
                ST_PAUSE: state_d = go_amisha ? ST_RUN : ST_PAUSE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Tick fires on the last prescaler count in RUN, unless the cycle is being cleared.
    always_comb begin
        tick_s = (state_q == ST_RUN) && (presc_q == PRESC_LAST)
                 && !clr_amisha && !reset_amisha;
    end

    // Prescaler advances only in RUN, so PAUSE keeps the partial tick period.
    always_comb begin
        presc_d = presc_q;
        if (clr_amisha) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // End-of-range detect: all 9s counting up, all 0s counting down.
    always_comb begin
        all_nine_s = 1'b1;
        all_zero_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            all_nine_s = all_nine_s & (d_s[4*i +: 4] == BCD_MAX);
            all_zero_s = all_zero_s & (d_s[4*i +: 4] == BCD_MIN);
        end
        at_end_s = up_amisha ? all_nine_s : all_zero_s;
    end

    // Saturating build suppresses the step at the end of range; wrapping lets
    // the natural BCD rollover happen and reads the event off the final carry.
    always_comb begin
        if (WRAP != 0) begin
            step_en_s   = tick_s;
            end_event_s = carry_s[NUM_DIGITS];
        end else begin
            step_en_s   = tick_s & ~at_end_s;
            end_event_s = tick_s & at_end_s;
        end
    end

    // Sticky overflow, cleared only by clear (reset handled in the register).
    always_comb begin
        ovf_d = ovf_q;
        if (clr_amisha) begin
            ovf_d = 1'b0;
        end else if (end_event_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    assign carry_s[0] = 1'b1;

    genvar g;
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk   (clk_amisha),
            .reset (reset_amisha),
            .clr   (clr_amisha),
            .en    (step_en_s),
            .up    (up_amisha),
            .cin   (carry_s[g]),
            .q     (d_s[4*g +: 4]),
            .cout  (carry_s[g+1])
        );
    end

    // Control state registers.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign d_amisha       = d_s;
    assign tick_amisha    = tick_s;
    assign running_amisha = (state_q == ST_RUN);
    assign ovf_amisha     = ovf_q;

`ifdef STOP_WATCH_LAP_EN
    logic [4*NUM_DIGITS-1:0] lap_d_q;
    logic [4*NUM_DIGITS-1:0] lap_d_d;
    logic                    lap_valid_q;
    logic                    lap_valid_d;

    // Lap captures the digits shown this cycle (pre-tick value); ignored in IDLE.
    always_comb begin
        lap_d_d     = lap_d_q;
        lap_valid_d = lap_valid_q;
        if (clr_amisha) begin
            lap_d_d     = '0;
            lap_valid_d = 1'b0;
        end else if (lap_amisha && (state_q != ST_IDLE)) begin
            lap_d_d     = d_s;
            lap_valid_d = 1'b1;
        end else begin
            lap_d_d     = lap_d_q;
            lap_valid_d = lap_valid_q;
        end
    end

    // Lap registers.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            lap_d_q     <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_d_q     <= lap_d_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_d_amisha     = lap_d_q;
    assign lap_valid_amisha = lap_valid_q;
`endif

endmodule

// File: tb/tb_stop_watch_bcd_param.sv
// -----------------------------------------------------------------------------
// tb_stop_watch_bcd_param
// Two stopwatches (WRAP=1 and WRAP=0, 3 digits, TICK_DIV=4) driven by the same
// inputs and compared every cycle against an arithmetic reference model that
// keeps the count as an integer, plus directed table vectors and corner cases.
// -----------------------------------------------------------------------------
module tb_stop_watch_bcd_param;

    localparam int ND   = 3;
    localparam int TD   = 4;
    localparam int MAXV = 999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic go  = 1'b0;
    logic clr = 1'b0;
    logic up  = 1'b1;

    logic [11:0] d1, d0;
    logic        tick1, tick0, run1, run0, ovf1, ovf0;
`ifdef STOP_WATCH_LAP_EN
    logic        lap = 1'b0;
    logic [11:0] lapd1, lapd0;
    logic        lapv1, lapv0;
`endif

    stop_watch_bcd_param #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP(1)) u_dut_wrap (
        .clk_amisha      (clk),
        .reset_amisha    (rst),
        .go_amisha       (go),
        .clr_amisha      (clr),
        .up_amisha       (up),
        .d_amisha        (d1),
        .tick_amisha     (tick1),
        .running_amisha  (run1),
        .ovf_amisha      (ovf1)
`ifdef STOP_WATCH_LAP_EN
        ,
        .lap_amisha      (lap),
        .lap_d_amisha    (lapd1),
        .lap_valid_amisha(lapv1)
`endif
    );

    stop_watch_bcd_param #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP(0)) u_dut_sat (
        .clk_amisha      (clk),
        .reset_amisha    (rst),
        .go_amisha       (go),
        .clr_amisha      (clr),
        .up_amisha       (up),
        .d_amisha        (d0),
        .tick_amisha     (tick0),
        .running_amisha  (run0),
        .ovf_amisha      (ovf0)
`ifdef STOP_WATCH_LAP_EN
        ,
        .lap_amisha      (lap),
        .lap_d_amisha    (lapd0),
        .lap_valid_amisha(lapv0)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // reference model: 0 idle, 1 run, 2 pause; counts held as plain integers
    int m_state = 0;
    int m_presc = 0;
    int m_val1  = 0;
    int m_val0  = 0;
    bit m_ovf1  = 1'b0;
    bit m_ovf0  = 1'b0;
    bit m_valid = 1'b0;
    int m_lapd1 = 0;
    int m_lapd0 = 0;
    bit m_lapv  = 1'b0;
    bit last_tick;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_tick();
        return m_valid && !rst && !clr && (m_state == 1) && (m_presc == TD - 1);
    endfunction

    task automatic model_zero();
        m_state = 0; m_presc = 0; m_val1 = 0; m_val0 = 0;
        m_ovf1 = 1'b0; m_ovf0 = 1'b0; m_lapd1 = 0; m_lapd0 = 0; m_lapv = 1'b0;
    endtask

    task automatic model_edge();
        bit tk;
        if (rst) begin
            model_zero();
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (clr) begin
                model_zero();
            end else begin
                tk = (m_state == 1) && (m_presc == TD - 1);
`ifdef STOP_WATCH_LAP_EN
                if (lap && m_state != 0) begin
                    m_lapd1 = m_val1; m_lapd0 = m_val0; m_lapv = 1'b1;
                end
`endif
                if (m_state == 1) m_presc = (m_presc + 1) % TD;
                if (tk) begin
                    if (up) begin
                        if (m_val1 == MAXV) begin m_val1 = 0; m_ovf1 = 1'b1; end
                        else m_val1 = m_val1 + 1;
                        if (m_val0 == MAXV) m_ovf0 = 1'b1;
                        else m_val0 = m_val0 + 1;
                    end else begin
                        if (m_val1 == 0) begin m_val1 = MAXV; m_ovf1 = 1'b1; end
                        else m_val1 = m_val1 - 1;
                        if (m_val0 == 0) m_ovf0 = 1'b1;
                        else m_val0 = m_val0 - 1;
                    end
                end
                if (m_state == 0) m_state = go ? 1 : 0;
                else m_state = go ? 1 : 2;
            end
        end
    endtask

    // one clock: compare at the negedge, advance the model at the posedge
    task automatic step();
        @(negedge clk);
        last_tick = tick1;
        if (m_valid) begin
            chk("model_d_wrap", 32'(d1), 32'(to_bcd(m_val1)));
            chk("model_d_sat", 32'(d0), 32'(to_bcd(m_val0)));
            chk("model_tick_wrap", 32'(tick1), 32'(m_tick()));
            chk("model_tick_sat", 32'(tick0), 32'(m_tick()));
            chk("model_running", 32'({run1, run0}), 32'({2{m_state == 1}}));
            chk("model_ovf_wrap", 32'(ovf1), 32'(m_ovf1));
            chk("model_ovf_sat", 32'(ovf0), 32'(m_ovf0));
`ifdef STOP_WATCH_LAP_EN
            chk("model_lap_valid", 32'({lapv1, lapv0}), 32'({2{m_lapv}}));
            chk("model_lap_d_wrap", 32'(lapd1), 32'(to_bcd(m_lapd1)));
            chk("model_lap_d_sat", 32'(lapd0), 32'(to_bcd(m_lapd0)));
`endif
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        rst, go, clr, up;
        int          cycles;
        logic [11:0] exp_d1, exp_d0;
        logic        exp_run, exp_ovf1, exp_ovf0;
    } vec_t;

    vec_t tbl[14];
    int   first;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2,    12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 41,   12'h010, 12'h010, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1,    12'h010, 12'h010, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5,    12'h010, 12'h010, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,    12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 229,  12'h057, 12'h057, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,    12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1,    12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3997, 12'h999, 12'h999, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4,    12'h000, 12'h999, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8,    12'h002, 12'h999, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,    12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 5,    12'h999, 12'h000, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1,    12'h000, 12'h000, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; go = tbl[i].go; clr = tbl[i].clr; up = tbl[i].up;
            repeat (tbl[i].cycles) step();
            chk($sformatf("vec%0d_d_wrap", i), 32'(d1), 32'(tbl[i].exp_d1));
            chk($sformatf("vec%0d_d_sat", i), 32'(d0), 32'(tbl[i].exp_d0));
            chk($sformatf("vec%0d_running", i), 32'(run1), 32'(tbl[i].exp_run));
            chk($sformatf("vec%0d_ovf_wrap", i), 32'(ovf1), 32'(tbl[i].exp_ovf1));
            chk($sformatf("vec%0d_ovf_sat", i), 32'(ovf0), 32'(tbl[i].exp_ovf0));
        end
        chk("reset_then_clear_tick", 32'(tick1), 32'(1'b0));

        // pause with prescaler at 2, resume: tick lands two cycles after go
        rst = 1'b0; clr = 1'b0; go = 1'b1; up = 1'b1;
        repeat (6) step();
        go = 1'b0;
        repeat (8) step();
        chk("paused_running", 32'(run1), 32'(1'b0));
        go = 1'b1;
        first = -1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_tick && first < 0) first = i;
        end
        chk("resume_tick_latency", 32'(first), 32'(2));
        chk("resume_d", 32'(d1), 32'(12'h002));

`ifdef STOP_WATCH_LAP_EN
        // lap in IDLE is ignored
        go = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; lap = 1'b1;
        step();
        lap = 1'b0;
        chk("lap_idle_ignored", 32'(lapv1), 32'(1'b0));
        go = 1'b1; up = 1'b1;
        repeat (93) step();
        chk("lap_pre_d", 32'(d1), 32'(12'h023));
        lap = 1'b1;
        step();
        lap = 1'b0;
        chk("lap_capture_d", 32'(lapd1), 32'(12'h023));
        chk("lap_capture_valid", 32'(lapv1), 32'(1'b1));
        repeat (10) step();
        chk("lap_tick_cycle", 32'({tick1, d1}), 32'({1'b1, 12'h025}));
        lap = 1'b1;
        step();
        lap = 1'b0;
        chk("lap_on_tick_pre", 32'(lapd1), 32'(12'h025));
        chk("lap_on_tick_d", 32'(d1), 32'(12'h026));
`endif

        // randomized phase against the reference model
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(127) == 0);
            clr = ($urandom_range(63) == 0);
            go  = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) up = ~up;
`ifdef STOP_WATCH_LAP_EN
            lap = ($urandom_range(7) == 0);
`endif
            step();
        end

        // long run upward then downward through both ends of range
        rst = 1'b0; clr = 1'b0; go = 1'b1; up = 1'b1;
`ifdef STOP_WATCH_LAP_EN
        lap = 1'b0;
`endif
        repeat (4100) step();
        up = 1'b0;
        repeat (200) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
